// File: rtl/dma_read_engine.sv
// Streaming DMA read engine: issues word reads to memory with a bounded number
// in flight and forwards the in-order read data to the layer controller.
module dma_read_engine #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  output logic              dma_engineer_ack,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              busy
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0]  OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]  OUT_ONE = OUT_W'(1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic [ADDR_W-1:0] issued;
  logic [ADDR_W-1:0] received;
  logic [OUT_W-1:0]  outstanding;
  logic              grant;
  logic              rd_take;

  // Ack and mem_rd_req are suppressed during reset so an abort takes effect at once.
  always_comb begin
    state_nxt        = state;
    dma_engineer_ack = 1'b0;
    mem_rd_req       = 1'b0;
    case (state)
      IDLE: begin
        if (dma_engineer_req && !rst) begin
          dma_engineer_ack = 1'b1;
          if (dma_engineer_length != '0) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_req = !rst && (issued < length) && (outstanding < OUT_MAX);
        if (issued == length) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (received == length) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant       = mem_rd_req & mem_rd_gnt;
  assign rd_take     = mem_rd_valid & (state != IDLE);
  assign mem_rd_addr = start_addr + issued;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      start_addr            <= '0;
      length                <= '0;
      issued                <= '0;
      received              <= '0;
      outstanding           <= '0;
      dma_engineer_dout     <= '0;
      dma_engineer_dout_en  <= 1'b0;
      dma_engineer_dout_eop <= 1'b0;
    end else begin
      state                 <= state_nxt;
      dma_engineer_dout_en  <= rd_take;
      dma_engineer_dout_eop <= rd_take && (received == length - ONE);
      if (rd_take) dma_engineer_dout <= mem_rd_data;

      if (dma_engineer_ack) begin
        start_addr  <= dma_engineer_start_addr;
        length      <= dma_engineer_length;
        issued      <= '0;
        received    <= '0;
        outstanding <= '0;
      end else begin
        if (grant)   issued   <= issued + ONE;
        if (rd_take) received <= received + ONE;
        // A grant and a returning word in the same cycle cancel out.
        case ({grant, rd_take})
          2'b10:   outstanding <= outstanding + OUT_ONE;
          2'b01:   outstanding <= outstanding - OUT_ONE;
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_read_engine.sv
// Self-checking bench for dma_read_engine: an in-order memory model feeds a
// scoreboard of expected words, checked as the engine streams them out.
module tb_dma_read_engine;

  localparam int AW = 27;
  localparam int DW = 512;
  localparam int MO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          dma_engineer_req;
  logic          dma_engineer_ack;
  logic [AW-1:0] dma_engineer_start_addr;
  logic [AW-1:0] dma_engineer_length;
  logic [DW-1:0] dma_engineer_dout;
  logic          dma_engineer_dout_en;
  logic          dma_engineer_dout_eop;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_gnt;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          busy;

  always #5 clk = ~clk;

  dma_read_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .dma_engineer_req        (dma_engineer_req),
    .dma_engineer_ack        (dma_engineer_ack),
    .dma_engineer_start_addr (dma_engineer_start_addr),
    .dma_engineer_length     (dma_engineer_length),
    .dma_engineer_dout       (dma_engineer_dout),
    .dma_engineer_dout_en    (dma_engineer_dout_en),
    .dma_engineer_dout_eop   (dma_engineer_dout_eop),
    .mem_rd_req              (mem_rd_req),
    .mem_rd_addr             (mem_rd_addr),
    .mem_rd_gnt              (mem_rd_gnt),
    .mem_rd_data             (mem_rd_data),
    .mem_rd_valid            (mem_rd_valid),
    .busy                    (busy)
  );

  typedef struct {logic [AW-1:0] addr; int due;} ret_t;
  typedef struct {logic [DW-1:0] data; logic eop;} exp_t;

  ret_t          ret_q[$];
  exp_t          sb_q[$];
  logic [AW-1:0] addr_log[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit model_active = 0;
  bit gnt_random   = 0;
  bit valid_random = 0;
  bit mem_hold     = 0;
  bit stray        = 0;
  int lat          = 3;

  logic [AW-1:0] model_base   = '0;
  logic [AW-1:0] model_len    = '0;
  logic [AW-1:0] model_issued = '0;
  int model_out = 0;
  int max_out   = 0;

  int dout_cnt  = 0;
  int eop_cnt   = 0;
  int ack_cnt   = 0;
  int grant_cnt = 0;
  int req_cnt   = 0;
  int both_cnt  = 0;
  logic [DW-1:0] last_dout = '0;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++)
      w[i*32 +: 32] = {5'b0, a} ^ (32'h9E3779B9 * (i + 1));
    return w;
  endfunction

  // Memory model and output scoreboard, evaluated every falling edge.
  initial begin
    bit   g, granted, v, exp_req;
    exp_t e;
    ret_t r;
    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mem_rd_gnt   = 1'b0;
        mem_rd_valid = 1'b0;
        continue;
      end
      if (dma_engineer_ack) ack_cnt++;
      if (mem_rd_req) req_cnt++;

      if (dma_engineer_dout_en) begin
        dout_cnt++;
        if (dma_engineer_dout_eop) eop_cnt++;
        last_dout = dma_engineer_dout;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_dout: dout_en=1, expected 0 (nothing outstanding)");
        end else begin
          e = sb_q.pop_front();
          if (dma_engineer_dout !== e.data) begin
            n_fail++;
            $display("[TB] FAIL dout_data: got %h, expected %h", dma_engineer_dout, e.data);
          end
          n_tests++;
          if (dma_engineer_dout_eop !== e.eop) begin
            n_fail++;
            $display("[TB] FAIL dout_eop: got %b, expected %b", dma_engineer_dout_eop, e.eop);
          end
        end
      end else begin
        n_tests++;
        if (dma_engineer_dout_eop !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL eop_without_en: got %b, expected 0", dma_engineer_dout_eop);
        end
        n_tests++;
        if (dma_engineer_dout !== last_dout) begin
          n_fail++;
          $display("[TB] FAIL dout_hold: got %h, expected %h", dma_engineer_dout, last_dout);
        end
      end

      if (model_active) begin
        exp_req = (model_issued < model_len) && (model_out < MO);
        n_tests++;
        if (mem_rd_req !== exp_req) begin
          n_fail++;
          $display("[TB] FAIL req_gate: got %b, expected %b (issued=%0d out=%0d)",
                   mem_rd_req, exp_req, model_issued, model_out);
        end
        if (mem_rd_req) begin
          n_tests++;
          if (mem_rd_addr !== model_base + model_issued) begin
            n_fail++;
            $display("[TB] FAIL rd_addr: got %h, expected %h", mem_rd_addr, model_base + model_issued);
          end
        end
      end else if (mem_rd_req) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL req_idle: mem_rd_req=1, expected 0");
      end

      g          = gnt_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      mem_rd_gnt = g;
      granted    = mem_rd_req && g;

      v = 1'b0;
      if (stray) begin
        v           = 1'b1;
        mem_rd_data = word_of('1);
        stray       = 0;
      end else if (!mem_hold && ret_q.size() > 0 && ret_q[0].due <= cyc &&
                   (!valid_random || $urandom_range(0, 1) == 1)) begin
        r           = ret_q.pop_front();
        mem_rd_data = word_of(r.addr);
        v           = 1'b1;
        model_out--;
      end
      mem_rd_valid = v;

      if (granted) begin
        ret_q.push_back('{addr: mem_rd_addr, due: cyc + lat});
        sb_q.push_back('{data: word_of(mem_rd_addr), eop: (model_issued == model_len - 1)});
        addr_log.push_back(mem_rd_addr);
        model_issued++;
        model_out++;
        grant_cnt++;
        if (model_out > max_out) max_out = model_out;
        if (v) both_cnt++;
      end
    end
  end

  task automatic reset_counters();
    dout_cnt  = 0;
    eop_cnt   = 0;
    ack_cnt   = 0;
    grant_cnt = 0;
    req_cnt   = 0;
    both_cnt  = 0;
    max_out   = 0;
    addr_log.delete();
  endtask

  task automatic start_xfer(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                            input bit hold_req, output logic ack0, output logic ack1);
    @(posedge clk); #2;
    dma_engineer_req        = 1'b1;
    dma_engineer_start_addr = addr;
    dma_engineer_length     = len;
    #1 ack0 = dma_engineer_ack;
    @(posedge clk); #2;
    model_base   = addr;
    model_len    = len;
    model_issued = '0;
    model_out    = 0;
    model_active = (len != 0);
    if (!hold_req) dma_engineer_req = 1'b0;
    #1 ack1 = dma_engineer_ack;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!busy && ret_q.size() == 0 && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    dma_engineer_req = 1'b0;
    model_active     = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dma_engineer_req = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_tests++; if (dma_engineer_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ack: got %b, expected 0", dma_engineer_ack); end
    n_tests++; if (dma_engineer_dout_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_dout_en: got %b, expected 0", dma_engineer_dout_en); end
    n_tests++; if (dma_engineer_dout_eop !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_eop: got %b, expected 0", dma_engineer_dout_eop); end
    n_tests++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rd_req: got %b, expected 0", mem_rd_req); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b, expected 0", busy); end
    n_tests++; if (dma_engineer_dout !== '0) begin n_fail++; $display("[TB] FAIL rst_dout: got %h, expected 0", dma_engineer_dout); end
    n_tests++; if (mem_rd_addr !== '0) begin n_fail++; $display("[TB] FAIL rst_rd_addr: got %h, expected 0", mem_rd_addr); end
    dma_engineer_req = 1'b0;
    last_dout = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic a0, a1;
    bit ok;
    reset_counters();
    start_xfer(27'd2500, 27'd128, 0, a0, a1);
    n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ack: got %b, expected 1", a0); end
    n_tests++; if (a1 !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ack_pulse: got %b, expected 0", a1); end
    wait_done(800, ok);
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_timeout: done=0, expected 1"); end
    n_tests++; if (dout_cnt != 128) begin n_fail++; $display("[TB] FAIL basic_count: got %0d, expected 128", dout_cnt); end
    n_tests++; if (eop_cnt != 1) begin n_fail++; $display("[TB] FAIL basic_eop_count: got %0d, expected 1", eop_cnt); end
    n_tests++; if (ack_cnt != 1) begin n_fail++; $display("[TB] FAIL basic_ack_count: got %0d, expected 1", ack_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy: got %b, expected 0", busy); end
    n_tests++;
    if (addr_log.size() != 128) begin
      n_fail++; $display("[TB] FAIL basic_grants: got %0d, expected 128", addr_log.size());
    end else if (addr_log[0] !== 27'd2500 || addr_log[127] !== 27'd2627) begin
      n_fail++; $display("[TB] FAIL basic_addr_range: got %0d..%0d, expected 2500..2627", addr_log[0], addr_log[127]);
    end
  endtask

  task automatic test_zero_len();
    logic a0, a1;
    reset_counters();
    start_xfer(27'd100, 27'd0, 0, a0, a1);
    repeat (10) @(posedge clk);
    #2;
    n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ack: got %b, expected 1", a0); end
    n_tests++; if (ack_cnt != 1) begin n_fail++; $display("[TB] FAIL zero_ack_count: got %0d, expected 1", ack_cnt); end
    n_tests++; if (req_cnt != 0) begin n_fail++; $display("[TB] FAIL zero_rd_req: got %0d, expected 0", req_cnt); end
    n_tests++; if (dout_cnt != 0) begin n_fail++; $display("[TB] FAIL zero_dout: got %0d, expected 0", dout_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_outstanding_limit();
    logic a0, a1;
    bit ok;
    reset_counters();
    mem_hold = 1;
    start_xfer(27'd4000, 27'd32, 0, a0, a1);
    repeat (40) @(posedge clk);
    #2;
    n_tests++; if (grant_cnt != MO) begin n_fail++; $display("[TB] FAIL limit_grants: got %0d, expected %0d", grant_cnt, MO); end
    n_tests++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("[TB] FAIL limit_req: got %b, expected 0", mem_rd_req); end
    mem_hold = 0;
    wait_done(400, ok);
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL limit_timeout: done=0, expected 1"); end
    n_tests++; if (dout_cnt != 32) begin n_fail++; $display("[TB] FAIL limit_count: got %0d, expected 32", dout_cnt); end
    n_tests++; if (eop_cnt != 1) begin n_fail++; $display("[TB] FAIL limit_eop: got %0d, expected 1", eop_cnt); end
  endtask

  task automatic test_wrap();
    logic a0, a1;
    bit ok;
    logic [AW-1:0] exp_a[4];
    exp_a = '{27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h0000001};
    reset_counters();
    start_xfer(27'h7FFFFFE, 27'd4, 0, a0, a1);
    wait_done(100, ok);
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL wrap_timeout: done=0, expected 1"); end
    n_tests++;
    if (addr_log.size() != 4) begin
      n_fail++; $display("[TB] FAIL wrap_grants: got %0d, expected 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (addr_log[i] !== exp_a[i]) begin
          n_fail++; $display("[TB] FAIL wrap_addr%0d: got %h, expected %h", i, addr_log[i], exp_a[i]);
        end
      end
    end
    n_tests++; if (eop_cnt != 1) begin n_fail++; $display("[TB] FAIL wrap_eop: got %0d, expected 1", eop_cnt); end
  endtask

  task automatic test_random();
    logic a0, a1;
    bit ok;
    reset_counters();
    gnt_random   = 1;
    valid_random = 1;
    lat          = 2;
    start_xfer(27'd9000, 27'd100, 0, a0, a1);
    wait_done(3000, ok);
    gnt_random   = 0;
    valid_random = 0;
    lat          = 3;
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL rand_timeout: done=0, expected 1"); end
    n_tests++; if (dout_cnt != 100) begin n_fail++; $display("[TB] FAIL rand_count: got %0d, expected 100", dout_cnt); end
    n_tests++; if (eop_cnt != 1) begin n_fail++; $display("[TB] FAIL rand_eop: got %0d, expected 1", eop_cnt); end
    n_tests++; if (max_out > MO) begin n_fail++; $display("[TB] FAIL rand_max_out: got %0d, expected <= %0d", max_out, MO); end
    n_tests++; if (both_cnt == 0) begin n_fail++; $display("[TB] FAIL rand_overlap: got %0d grant+valid cycles, expected > 0", both_cnt); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    bit reached;
    reset_counters();
    start_xfer(27'd2500, 27'd128, 0, a0, a1);
    reached = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (dout_cnt >= 10) begin
        reached = 1;
        break;
      end
    end
    n_tests++; if (!reached) begin n_fail++; $display("[TB] FAIL abort_progress: got %0d words, expected 10", dout_cnt); end
    rst          = 1'b1;
    model_active = 0;
    last_dout    = '0;
    @(posedge clk); #2;
    ret_q.delete();
    sb_q.delete();
    model_out = 0;
    rst       = 1'b0;
    stray     = 1;
    repeat (2) @(posedge clk);
    #2;
    n_tests++; if (dma_engineer_dout_en !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_dout_en: got %b, expected 0", dma_engineer_dout_en); end
    n_tests++; if (dma_engineer_dout !== '0) begin n_fail++; $display("[TB] FAIL abort_dout: got %h, expected 0", dma_engineer_dout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    n_tests++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_rd_req: got %b, expected 0", mem_rd_req); end
    n_tests++; if (mem_rd_addr !== '0) begin n_fail++; $display("[TB] FAIL abort_rd_addr: got %h, expected 0", mem_rd_addr); end
    n_tests++; if (eop_cnt != 0) begin n_fail++; $display("[TB] FAIL abort_eop: got %0d, expected 0", eop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1;
    bit ok;
    reset_counters();
    start_xfer(27'd500, 27'd8, 1, a0, a1);
    n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ack: got %b, expected 1", a0); end
    wait_done(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL b2b_timeout1: done=0, expected 1"); end
    n_tests++; if (ack_cnt != 1) begin n_fail++; $display("[TB] FAIL b2b_held_req: got %0d acks, expected 1", ack_cnt); end
    start_xfer(27'd600, 27'd6, 0, a0, a1);
    wait_done(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("[TB] FAIL b2b_timeout2: done=0, expected 1"); end
    n_tests++; if (dout_cnt != 14) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d, expected 14", dout_cnt); end
    n_tests++; if (eop_cnt != 2) begin n_fail++; $display("[TB] FAIL b2b_eop: got %0d, expected 2", eop_cnt); end
    n_tests++; if (ack_cnt != 2) begin n_fail++; $display("[TB] FAIL b2b_ack_count: got %0d, expected 2", ack_cnt); end
    n_tests++;
    if (addr_log.size() != 14) begin
      n_fail++; $display("[TB] FAIL b2b_grants: got %0d, expected 14", addr_log.size());
    end else if (addr_log[8] !== 27'd600) begin
      n_fail++; $display("[TB] FAIL b2b_second_addr: got %0d, expected 600", addr_log[8]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst                     = 1'b1;
    dma_engineer_req        = 1'b0;
    dma_engineer_start_addr = '0;
    dma_engineer_length     = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_outstanding_limit();
    test_wrap();
    test_random();
    test_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
